// File: rtl/div_pkg.sv
// Shared types and sign helpers for the restoring divider family.
// Helpers work on DIV_MAX_W-bit values; callers extend and truncate to their own width.
package div_pkg;

    localparam int DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The value must already be sign-extended when is_signed is set.
    function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] value,
                                                     input logic                 is_signed);
        if (is_signed && value[DIV_MAX_W-1])
            return -value;
        return value;
    endfunction

    function automatic logic [DIV_MAX_W-1:0] neg_if(input logic [DIV_MAX_W-1:0] value,
                                                    input logic                 flag);
        return flag ? -value : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when it is non-negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p,
    output logic [WIDTH-1:0] o_a
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // The stored remainder is always below the divisor, so its top bit of the
    // WIDTH+1-bit partial remainder is zero between steps and is not kept.
    assign w_shifted = {i_p, i_a[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, i_b};

    always_comb begin
        o_p = w_shifted[WIDTH-1:0];
        o_a = {i_a[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            o_p = w_trial[WIDTH-1:0];
            o_a = {i_a[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential signed/unsigned restoring divider, one quotient bit per clock; result WIDTH+1
// cycles after accept (1 for divide-by-zero), held in DONE until out_ready.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PAD_W = DIV_MAX_W - WIDTH;

    state_t           r_state;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_q_sign;
    logic             r_r_sign;
    logic             r_dbz;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_rem;
    logic             r_div_by_zero;

    logic [DIV_MAX_W-1:0] w_a_ext;
    logic [DIV_MAX_W-1:0] w_b_ext;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic [WIDTH-1:0]     w_p_next;
    logic [WIDTH-1:0]     w_a_next;
    logic [WIDTH-1:0]     w_q_fixed;
    logic [WIDTH-1:0]     w_r_fixed;
    logic                 w_b_zero;

    assign w_a_ext  = {{PAD_W{A[WIDTH-1] & is_signed}}, A};
    assign w_b_ext  = {{PAD_W{B[WIDTH-1] & is_signed}}, B};
    // Magnitude of the most-negative value fits unsigned in WIDTH bits.
    assign w_a_abs  = WIDTH'(abs_val(w_a_ext, is_signed));
    assign w_b_abs  = WIDTH'(abs_val(w_b_ext, is_signed));
    assign w_b_zero = (B == '0);

    assign w_q_fixed = WIDTH'(neg_if({{PAD_W{1'b0}}, r_a}, r_q_sign));
    assign w_r_fixed = WIDTH'(neg_if({{PAD_W{1'b0}}, r_dbz ? r_a : r_p}, r_r_sign));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_p(r_p),
        .i_a(r_a),
        .i_b(r_b),
        .o_p(w_p_next),
        .o_a(w_a_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_p           <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_q_sign      <= 1'b0;
            r_r_sign      <= 1'b0;
            r_dbz         <= 1'b0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_res         <= '0;
            r_rem         <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= w_a_abs;
                        r_b      <= w_b_abs;
                        r_p      <= '0;
                        r_q_sign <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_r_sign <= is_signed & A[WIDTH-1];
                        r_dbz    <= w_b_zero;
                        r_cnt    <= '0;
                        // Divide-by-zero skips the iterations but still spends one
                        // cycle in FIX so the result lands one edge after accept.
                        r_state  <= w_b_zero ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_p   <= w_p_next;
                    r_a   <= w_a_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_res         <= r_dbz ? '1 : w_q_fixed;
                    r_rem         <= w_r_fixed;
                    r_div_by_zero <= r_dbz;
                    r_out_valid   <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE) && !rst;
    assign out_valid   = r_out_valid;
    assign Res         = r_res;
    assign rem         = r_rem;
    assign div_by_zero = r_div_by_zero;

endmodule
